// File: rtl/interrupt_ctrl_pkg.sv
// interrupt_ctrl_pkg: register addresses, source indices, vector layout and FSM states
package interrupt_ctrl_pkg;
  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;
  localparam int SRC_VBLANK = 0;
  localparam int SRC_LCDSTAT = 1;
  localparam int SRC_TIMER = 2;
  localparam int SRC_SERIAL = 3;
  localparam int SRC_JOYPAD = 4;
  localparam logic [7:0] VEC_BASE = 8'h40;
  localparam logic [7:0] VEC_STRIDE = 8'h08;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;
  function automatic logic [7:0] vector_of(input logic [2:0] idx);
    return VEC_BASE + VEC_STRIDE * {5'd0, idx};
  endfunction
endpackage

// File: rtl/interrupt_ctrl_if.sv
// interrupt_ctrl_if: CPU memory bus plus interrupt dispatch handshake
interface interrupt_ctrl_if;
  logic [15:0] address;
  logic [7:0] indata;
  logic [7:0] outdata;
  logic load;
  logic store;
  logic ime;
  logic int_pending;
  logic int_valid;
  logic [7:0] int_vector;
  logic int_ack;
  modport master (output address, indata, load, store, ime, int_ack,
                  input outdata, int_pending, int_valid, int_vector);
  modport slave (input address, indata, load, store, ime, int_ack,
                 output outdata, int_pending, int_valid, int_vector);
endinterface

// File: rtl/interrupt_ctrl_prio.sv
// int_prio: lowest-numbered set bit of the masked request wins
module int_prio
  import interrupt_ctrl_pkg::*;
(
  input  logic [4:0] req,
  output logic       valid,
  output logic [2:0] idx
);
  always_comb begin
    valid = |req;
    idx = req[SRC_VBLANK]  ? 3'(SRC_VBLANK)  :
          req[SRC_LCDSTAT] ? 3'(SRC_LCDSTAT) :
          req[SRC_TIMER]   ? 3'(SRC_TIMER)   :
          req[SRC_SERIAL]  ? 3'(SRC_SERIAL)  : 3'(SRC_JOYPAD);
  end
endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers with a three-state dispatch handshake to the CPU
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
(
  input  logic       clockgb,
  input  logic       resetn,
  input  logic [4:0] int_req,
  output logic [4:0] dint_if,
  interrupt_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [4:0] if_r, if_n, masked;
  logic [7:0] ie_r, ie_n;
  logic [2:0] idx, idx_n, hit_idx;
  logic hit, wr_if, wr_ie, ack;
  assign masked = if_r & ie_r[4:0];
  int_prio u_prio (.req(masked), .valid(hit), .idx(hit_idx));
  assign wr_if = bus.store && bus.address == IF_ADDR;
  assign wr_ie = bus.store && bus.address == IE_ADDR;
  assign ack = state == REQ && bus.int_ack;
  always_comb begin
    ie_n = wr_ie ? bus.indata : ie_r;
    if_n = wr_if ? bus.indata[4:0] : if_r;
    if (ack) if_n[idx] = 1'b0;
    // new requests are OR'd last so a same-edge event survives ack or store
    if_n = if_n | int_req;
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: if (bus.ime && hit) begin
        state_n = REQ;
        idx_n = hit_idx;
      end
      REQ: state_n = ack ? HOLD : (if_n[idx] && ie_n[idx]) ? REQ : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      if_r <= '0;
      ie_r <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if_r <= if_n;
      ie_r <= ie_n;
      idx <= idx_n;
    end
  end
  always_comb begin
    bus.int_valid = state == REQ;
    bus.int_vector = bus.int_valid ? vector_of(idx) : 8'h00;
    bus.int_pending = |masked;
    bus.outdata = (bus.load && bus.address == IF_ADDR) ? {3'b111, if_r} :
                  (bus.load && bus.address == IE_ADDR) ? ie_r : 8'h00;
    dint_if = if_r;
  end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: directed scenarios plus random traffic against a dispatch model
module tb_interrupt_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [4:0] int_req = '0;
  logic [4:0] dint_if;
  bit chk_on = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  interrupt_ctrl_if bus ();
  interrupt_ctrl dut (.clockgb(clk), .resetn(resetn), .int_req(int_req), .dint_if(dint_if), .bus(bus));
  always #5 clk = ~clk;

  logic [4:0] m_if;
  logic [7:0] m_ie;
  int m_phase;
  int m_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 = waiting, 1 = offering vector, 2 = one blocked cycle after ack
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_if <= '0;
      m_ie <= '0;
      m_phase <= 0;
      m_idx <= 0;
    end else begin : upd
      logic [4:0] nif;
      logic [7:0] nie;
      logic [4:0] pend;
      int nph, nidx;
      bit acked;
      nie = (bus.store && bus.address == 16'hFFFF) ? bus.indata : m_ie;
      nif = (bus.store && bus.address == 16'hFF0F) ? bus.indata[4:0] : m_if;
      acked = m_phase == 1 && bus.int_ack;
      if (acked) nif[m_idx] = 1'b0;
      nif = nif | int_req;
      nph = m_phase;
      nidx = m_idx;
      pend = m_if & m_ie[4:0];
      if (m_phase == 0) begin
        if (bus.ime && pend != 0) begin
          nph = 1;
          for (int i = 4; i >= 0; i--) if (pend[i]) nidx = i;
        end
      end else if (m_phase == 1) begin
        if (acked) nph = 2;
        else if (!(nif[m_idx] && nie[m_idx])) nph = 0;
      end else nph = 0;
      m_if <= nif;
      m_ie <= nie;
      m_phase <= nph;
      m_idx <= nidx;
    end
  end

  always @(negedge clk) begin
    if (chk_on && resetn) begin
      chk("valid", bus.int_valid, m_phase == 1);
      chk("vector", bus.int_vector, m_phase == 1 ? 32'h40 + 8 * m_idx : 0);
      chk("pending", bus.int_pending, (m_if & m_ie[4:0]) != 0);
      chk("dint_if", dint_if, m_if);
      chk("outdata", bus.outdata,
          !bus.load ? 0 : bus.address == 16'hFF0F ? {27'd0, 3'b111, m_if} :
          bus.address == 16'hFFFF ? {24'd0, m_ie} : 0);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.store = 0;
    bus.load = 0;
    bus.int_ack = 0;
    int_req = '0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.store = 1;
    bus.address = a;
    bus.indata = d;
    cyc();
    bus.store = 0;
  endtask

  task automatic pulse_req(input logic [4:0] r);
    int_req = r;
    cyc();
    int_req = '0;
  endtask

  task automatic ack_cyc();
    bus.int_ack = 1;
    cyc();
    bus.int_ack = 0;
  endtask

  initial begin
    bus.address = '0;
    bus.indata = '0;
    bus.ime = 0;
    quiet();
    repeat (2) cyc();
    chk("rst valid", bus.int_valid, 0);
    chk("rst vector", bus.int_vector, 0);
    chk("rst outdata", bus.outdata, 0);
    chk("rst dint_if", dint_if, 0);
    resetn = 1;
    chk_on = 1;
    // timer alone
    wr(16'hFFFF, 8'h04);
    bus.ime = 1;
    pulse_req(5'b00100);
    chk("t1 if", dint_if, 5'h04);
    cyc();
    chk("t1 valid", bus.int_valid, 1);
    chk("t1 vec", bus.int_vector, 8'h50);
    chk("t1 model vec", 32'h40 + 8 * m_idx, 32'h50);
    ack_cyc();
    chk("t1 if clr", dint_if, 0);
    chk("t1 hold", bus.int_valid, 0);
    chk("t1 model hold", m_phase, 2);
    cyc();
    chk("t1 idle", bus.int_valid, 0);
    // timer and joypad together: timer first
    wr(16'hFFFF, 8'h1F);
    pulse_req(5'h14);
    cyc();
    chk("t2 vec a", bus.int_vector, 8'h50);
    ack_cyc();
    chk("t2 hold", bus.int_valid, 0);
    cyc();
    cyc();
    chk("t2 vec b", bus.int_vector, 8'h60);
    ack_cyc();
    cyc();
    chk("t2 if", dint_if, 0);
    // ime gating
    bus.ime = 0;
    wr(16'hFFFF, 8'h01);
    pulse_req(5'h01);
    chk("t3 pending", bus.int_pending, 1);
    cyc();
    cyc();
    chk("t3 no valid", bus.int_valid, 0);
    bus.ime = 1;
    cyc();
    chk("t3 vec", bus.int_vector, 8'h40);
    ack_cyc();
    cyc();
    // re-request on ack edge is kept
    wr(16'hFFFF, 8'h04);
    pulse_req(5'h04);
    cyc();
    chk("t4 vec", bus.int_vector, 8'h50);
    bus.int_ack = 1;
    int_req = 5'h04;
    cyc();
    quiet();
    chk("t4 if kept", dint_if, 5'h04);
    chk("t4 hold", bus.int_valid, 0);
    cyc();
    cyc();
    chk("t4 second", bus.int_valid, 1);
    chk("t4 second vec", bus.int_vector, 8'h50);
    ack_cyc();
    cyc();
    // withdraw by clearing IF
    wr(16'hFFFF, 8'h02);
    pulse_req(5'h02);
    cyc();
    chk("t5 vec", bus.int_vector, 8'h48);
    wr(16'hFF0F, 8'h00);
    chk("t5 withdrawn", bus.int_valid, 0);
    chk("t5 model idle", m_phase, 0);
    bus.load = 1;
    bus.address = 16'hFF0F;
    #1;
    chk("t5 read if", bus.outdata, 8'hE0);
    bus.load = 0;
    cyc();
    chk("t5 stays idle", bus.int_valid, 0);
    // async reset mid-dispatch
    wr(16'hFFFF, 8'h01);
    pulse_req(5'h01);
    cyc();
    chk("t6 valid", bus.int_valid, 1);
    resetn = 0;
    #1;
    chk("t6 rst valid", bus.int_valid, 0);
    chk("t6 rst if", dint_if, 0);
    chk("t6 rst vec", bus.int_vector, 0);
    bus.load = 1;
    bus.address = 16'hFFFF;
    #1;
    chk("t6 rst ie", bus.outdata, 0);
    bus.load = 0;
    cyc();
    resetn = 1;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      quiet();
      case ($urandom_range(0, 3))
        0: bus.address = 16'hFF0F;
        1: bus.address = 16'hFFFF;
        2: bus.address = 16'(32'hFF00 + $urandom_range(0, 255));
        default: bus.address = 16'($urandom);
      endcase
      bus.indata = 8'($urandom);
      bus.store = $urandom_range(0, 7) == 0;
      bus.load = $urandom_range(0, 1) == 1;
      bus.int_ack = $urandom_range(0, 2) == 0;
      bus.ime = $urandom_range(0, 9) != 0;
      int_req = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'd0;
      cyc();
    end
    quiet();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have ports: clockgb  in  1  system clock, rising edge; resetn  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have port: int_req  in  5  one-cycle request pulses, [0] vblank, [1] lcdstat, [2] timer overflow, [3] serial, [4] joypad.
REQ-003 SHALL have ports: address  in  16; indata  in  8; outdata  out  8; load  in  1; store  in  1 (CPU memory bus).
REQ-004 SHALL have port: ime  in  1  CPU master interrupt enable.
REQ-005 SHALL have port: int_pending  out  1  (IF & IE[4:0]) != 0, independent of ime (HALT wake).
REQ-006 SHALL have ports: int_valid  out  1  dispatch request; int_vector  out  8  dispatch address low byte.
REQ-007 SHALL have port: int_ack  in  1  CPU accepts dispatch, one-cycle pulse.
REQ-008 SHALL have port: dint_if  out  5  debug copy of IF.

Function
REQ-009 SHALL hold IF[4:0] at 0xFF0F and IE[7:0] at 0xFFFF.
REQ-010 SHALL set IF[n] on any clock where int_req[n]=1.
REQ-011 SHALL, on store to 0xFF0F, load IF from indata[4:0] OR'd with the same-cycle int_req.
REQ-012 SHALL, on store to 0xFFFF, load IE from indata[7:0].
REQ-013 SHALL drive outdata combinationally: load && address==0xFF0F -> {3'b111, IF}; load && address==0xFFFF -> IE; otherwise 0x00.
REQ-014 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-015 IDLE: if ime=1 and (IF & IE[4:0])!=0, SHALL latch index idx of the lowest-numbered set bit and go to REQ next cycle; ime SHALL be sampled only in IDLE.
REQ-016 REQ: int_valid=1; int_vector=0x40+8*idx, held stable until exit; higher-priority requests arriving in REQ SHALL NOT change idx.
REQ-017 REQ with int_ack=1: SHALL clear IF[idx] on that edge and go to HOLD.
REQ-018 HOLD: int_valid=0; SHALL return to IDLE after exactly one cycle; blocks back-to-back dispatch before CPU clears ime.
REQ-019 Same-cycle int_req[idx]=1 and ack-clear of IF[idx]: set SHALL win, so the new event is kept.
REQ-020 A store clearing IF[idx] or IE[idx] while in REQ with no int_ack SHALL withdraw the request: next state IDLE, int_valid=0 next cycle; with int_ack the same cycle, ack wins.
REQ-021 int_ack outside REQ SHALL be ignored.
REQ-022 int_vector SHALL read 0x00 whenever int_valid=0.
REQ-023 int_pending SHALL be combinational from current IF/IE.

Reset
REQ-024 resetn=0 SHALL asynchronously force IF=0, IE=0, state=IDLE, idx=0, int_valid=0, int_vector=0x00, int_pending=0.
REQ-025 Reset mid-REQ SHALL drop int_valid immediately without acknowledging; the pending event is lost.
REQ-026 outdata SHALL be combinational and not reset-dependent; it reads 0x00 after reset when load=0.

Structure
REQ-027 Shared package SHALL hold: IF/IE addresses 0xFF0F/0xFFFF, source bit indices, vector base 0x40, vector stride 8, FSM state encodings.
REQ-028 SHALL instantiate one sub-module int_prio: 5-bit masked request in, valid plus 3-bit lowest-set index out, combinational.

Verification
REQ-029 IE=0x04, ime=1, int_req[2] pulse -> IF=0x04, int_valid=1 within 2 cycles, int_vector=0x50; ack -> IF=0x00, HOLD 1 cycle, then IDLE.
REQ-030 IE=0x1F, int_req=0x14 in one cycle, ime=1 -> int_vector=0x50; after ack and HOLD -> int_vector=0x60.
REQ-031 ime=0, IE=0x01, int_req[0] -> int_pending=1, int_valid stays 0; ime=1 -> int_vector=0x40.
REQ-032 In REQ for idx 2, int_req[2] pulses with int_ack -> IF[2] remains 1, second dispatch follows HOLD.
REQ-033 In REQ for idx 1, store 0x00 to 0xFF0F -> int_valid=0 next cycle, state IDLE; read 0xFF0F -> 0xE0.
REQ-034 resetn low while int_valid=1 -> int_valid, IF, IE all 0 before the next edge; read 0xFFFF -> 0x00.
